// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and result signals of the ALU issue stage.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface alu_cmd_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_opcode;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_num_1;
  logic [DATA_W-1:0] alu_num_2;
  logic [DATA_W-1:0] alu_ans;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [OP_W-1:0]   res_opcode;
  logic              res_err;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_ans, res_ready,
    output cmd_ready, alu_opcode, alu_num_1, alu_num_2,
           res_valid, res_data, res_opcode, res_err, busy
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_ans, res_ready,
    input  cmd_ready, alu_opcode, alu_num_1, alu_num_2,
           res_valid, res_data, res_opcode, res_err, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: command FIFO -> registered ALU drive -> result FIFO,
// with credit-based issue so results captured two edges later always have room.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
  localparam int unsigned RES_AW = $clog2(RES_DEPTH);
  localparam int unsigned CCNT_W = CMD_AW + 1;
  localparam int unsigned RCNT_W = RES_AW + 1;
  localparam int unsigned RSUM_W = RCNT_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [OP_W-1:0]   opcode;
    logic              err;
  } res_t;

  cmd_t              cmd_mem [CMD_DEPTH];
  logic [CMD_AW-1:0] cmd_wr_ptr;
  logic [CMD_AW-1:0] cmd_rd_ptr;
  logic [CCNT_W-1:0] cmd_count;

  res_t              res_mem [RES_DEPTH];
  logic [RES_AW-1:0] res_wr_ptr;
  logic [RES_AW-1:0] res_rd_ptr;
  logic [RCNT_W-1:0] res_count;

  logic              issue_v;
  logic              v1;
  logic [OP_W-1:0]   opc1;

  logic              cmd_push;
  logic              issue;
  logic              res_push;
  logic              res_pop;
  logic              opc1_err;
  logic [RSUM_W-1:0] inflight;
  cmd_t              cmd_head;
  res_t              res_head;

  assign cmd_head = cmd_mem[cmd_rd_ptr];
  assign res_head = res_mem[res_rd_ptr];

  // Results already held plus those still in the ALU pipeline must fit in the result FIFO.
  assign inflight = RSUM_W'(res_count) + RSUM_W'(issue_v) + RSUM_W'(v1);
  assign issue    = (cmd_count != '0) && (inflight < RSUM_W'(RES_DEPTH));

  assign bus.cmd_ready = (cmd_count != CCNT_W'(CMD_DEPTH));
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
  assign bus.res_valid = (res_count != '0);
  assign res_pop       = bus.res_valid && bus.res_ready;
  assign res_push      = v1;

  assign opc1_err = !((opc1 == OP_W'(4'h1)) || (opc1 == OP_W'(4'h2)) ||
                      (opc1 == OP_W'(4'h4)) || (opc1 == OP_W'(4'h8)));

  assign bus.res_data   = res_head.data;
  assign bus.res_opcode = res_head.opcode;
  assign bus.res_err    = res_head.err;
  assign bus.busy       = (cmd_count != '0) || issue_v || v1 || (res_count != '0);

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr] <= '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (res_push) begin
      res_mem[res_wr_ptr] <= '{data: bus.alu_ans, opcode: opc1, err: opc1_err};
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because depths are powers of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CMD_AW'(1);
      if (issue)    cmd_rd_ptr <= cmd_rd_ptr + CMD_AW'(1);
      cmd_count <= cmd_count + CCNT_W'(cmd_push) - CCNT_W'(issue);
      if (res_push) res_wr_ptr <= res_wr_ptr + RES_AW'(1);
      if (res_pop)  res_rd_ptr <= res_rd_ptr + RES_AW'(1);
      res_count <= res_count + RCNT_W'(res_push) - RCNT_W'(res_pop);
    end
  end

  // ALU drive and the one-cycle shadow that lines up with the ALU's registered answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_opcode <= '0;
      bus.alu_num_1  <= '0;
      bus.alu_num_2  <= '0;
      issue_v        <= 1'b0;
      v1             <= 1'b0;
      opc1           <= '0;
    end else begin
      issue_v <= issue;
      v1      <= issue_v;
      opc1    <= bus.alu_opcode;
      if (issue) begin
        bus.alu_opcode <= cmd_head.opcode;
        bus.alu_num_1  <= cmd_head.a;
        bus.alu_num_2  <= cmd_head.b;
      end else begin
        bus.alu_opcode <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural registered ALU
// (1:add 2:sub 4:mul 8:mod3, else 8'hFF).
module tb_alu_cmd_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_cmd_sequencer_if #(.DATA_W(8), .OP_W(4)) bus ();

  alu_cmd_sequencer #(
    .DATA_W(8), .OP_W(4), .CMD_DEPTH(4), .RES_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    case (bus.alu_opcode)
      4'h1:    bus.alu_ans <= bus.alu_num_1 + bus.alu_num_2;
      4'h2:    bus.alu_ans <= bus.alu_num_1 - bus.alu_num_2;
      4'h4:    bus.alu_ans <= bus.alu_num_1 * bus.alu_num_2;
      4'h8:    bus.alu_ans <= bus.alu_num_1 % 8'd3;
      default: bus.alu_ans <= 8'hFF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int   n = 0;
    logic ok;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    do begin
      ok = bus.cmd_ready;
      step();
      n++;
    end while (!ok && n < 40);
    check("push_accept", 32'(ok), 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!bus.res_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(bus.res_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;

    // Reset values
    #2;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    check("rst_alu_num_1", 32'(bus.alu_num_1), 32'd0);
    check("rst_alu_num_2", 32'(bus.alu_num_2), 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // Single op: latency of three edges from accept
    bus.res_ready = 1'b1;
    push(4'h1, 8'h05, 8'h03);
    check("lat_e0_valid", 32'(bus.res_valid), 32'd0);
    check("lat_e0_busy", 32'(bus.busy), 32'd1);
    step();
    check("lat_e1_valid", 32'(bus.res_valid), 32'd0);
    step();
    check("lat_e2_valid", 32'(bus.res_valid), 32'd0);
    step();
    check("lat_e3_valid", 32'(bus.res_valid), 32'd1);
    check("single_data", 32'(bus.res_data), 32'h08);
    check("single_opcode", 32'(bus.res_opcode), 32'h1);
    check("single_err", 32'(bus.res_err), 32'd0);
    step();
    check("single_popped", 32'(bus.res_valid), 32'd0);
    check("single_busy_clear", 32'(bus.busy), 32'd0);

    // Back-to-back stream, one result per cycle
    push(4'h1, 8'hFF, 8'h01);
    push(4'h2, 8'h03, 8'h05);
    push(4'h4, 8'h0F, 8'h0F);
    push(4'h8, 8'h09, 8'h5A);
    check("stream0_valid", 32'(bus.res_valid), 32'd1);
    check("stream0_data", 32'(bus.res_data), 32'h00);
    step();
    check("stream1_valid", 32'(bus.res_valid), 32'd1);
    check("stream1_data", 32'(bus.res_data), 32'hFE);
    check("stream1_opcode", 32'(bus.res_opcode), 32'h2);
    step();
    check("stream2_valid", 32'(bus.res_valid), 32'd1);
    check("stream2_data", 32'(bus.res_data), 32'hE1);
    step();
    check("stream3_valid", 32'(bus.res_valid), 32'd1);
    check("stream3_data", 32'(bus.res_data), 32'h00);
    check("stream3_opcode", 32'(bus.res_opcode), 32'h8);
    check("stream3_err", 32'(bus.res_err), 32'd0);
    step();
    check("stream_done", 32'(bus.res_valid), 32'd0);

    // Unsupported opcode still issues and is flagged
    push(4'h3, 8'h10, 8'h20);
    wait_res("inv_wait");
    check("inv_data", 32'(bus.res_data), 32'hFF);
    check("inv_opcode", 32'(bus.res_opcode), 32'h3);
    check("inv_err", 32'(bus.res_err), 32'd1);
    step();
    repeat (3) step();
    check("inv_idle", 32'(bus.busy), 32'd0);

    // Backpressure: eight commands, result FIFO fills, command FIFO fills
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(4'h1, 8'(i), 8'h10);
    check("bp_cmd_full", 32'(bus.cmd_ready), 32'd0);
    repeat (5) step();
    check("bp_cmd_still_full", 32'(bus.cmd_ready), 32'd0);
    check("bp_res_valid", 32'(bus.res_valid), 32'd1);
    check("bp_head", 32'(bus.res_data), 32'h10);
    check("bp_no_issue", 32'(bus.alu_opcode), 32'd0);
    check("bp_busy", 32'(bus.busy), 32'd1);

    // One-cycle pop at full; the freed slot is refilled by the next queued command
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("pulse_head", 32'(bus.res_data), 32'h11);
    repeat (5) step();
    check("pulse_valid", 32'(bus.res_valid), 32'd1);
    check("pulse_head_hold", 32'(bus.res_data), 32'h11);
    check("pulse_no_issue", 32'(bus.alu_opcode), 32'd0);
    check("pulse_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Drain the remaining seven in order
    bus.res_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      wait_res("drain_wait");
      check("drain_data", 32'(bus.res_data), 32'(8'h10 + 8'(i)));
      check("drain_opcode", 32'(bus.res_opcode), 32'h1);
      step();
    end
    repeat (4) step();
    check("drain_empty", 32'(bus.res_valid), 32'd0);
    check("drain_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of traffic
    bus.res_ready = 1'b0;
    push(4'h1, 8'h01, 8'h01);
    push(4'h1, 8'h02, 8'h01);
    push(4'h1, 8'h03, 8'h01);
    push(4'h1, 8'h04, 8'h01);
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    check("mid_alu_before", 32'(bus.alu_opcode), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    check("mid_rst_alu_num_1", 32'(bus.alu_num_1), 32'd0);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    bus.res_ready = 1'b1;
    push(4'h2, 8'h0A, 8'h04);
    wait_res("post_rst_wait");
    check("post_rst_data", 32'(bus.res_data), 32'h06);
    check("post_rst_opcode", 32'(bus.res_opcode), 32'h2);
    check("post_rst_err", 32'(bus.res_err), 32'd0);
    step();
    check("post_rst_drained", 32'(bus.res_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
